decode_issue_queue: RTL and testbench
=====================================

# decode_issue_queue

Parametrised decode/issue stage with an instruction queue between the fetcher and the RS/LSB/RoB. Buffers up to `IQ_DEPTH` fetched instructions, decodes the head entry, and issues it with operand values or dependency tags from the register file. It routes stall conditions per unit class, predicts next-PC for JAL/JALR/branches, and supports a full flush on RoB clear.

## Interface
Parameters:
- `IQ_DEPTH`, 4: queue entries; power of two, ≥2.
- `ROB_W`, 4: RoB tag width.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-high.
- `rdy`  in  1  global enable; low freezes all state and outputs.
- `clear`  in  1  RoB misprediction flush.
- `in_valid`  in  1  fetcher presents an instruction.
- `in_instr`  in  32  fetched instruction.
- `in_pc`  in  32  instruction address.
- `in_ready`  out  1  queue accepts a push this cycle (combinational).
- `pred_valid`  out  1  one-cycle redirect pulse to the fetcher.
- `pred_pc`  out  32  redirect target.
- `rob_full`, `rs_full`, `lsb_full`  in  1 each  downstream full flags.
- `reg_id1`, `reg_id2`  out  5 each  head rs1/rs2 (combinational).
- `reg_val1`, `reg_val2`  in  32 each  register values.
- `reg_dep1`, `reg_dep2`  in  1 each  operand pending.
- `reg_tag1`, `reg_tag2`  in  ROB_W each  producing RoB tag.
- `rob_id_in`  in  ROB_W  tag of the next RoB slot.
- `rob_id_out`  out  ROB_W  passthrough of `rob_id_in`.
- `issue_valid`  out  1  registered issue pulse.
- `instr_out`, `pc_out`  out  32 each  issued instruction and address.
- `type_out`  out  7  opcode.
- `op_out`  out  3  funct3.
- `imm_out`  out  32  decoded immediate.
- `rd_out`  out  5  destination register; 0 for B/S.
- `val1_out`, `val2_out`  out  32 each  operands. `val2_out` = imm when there is no rs2.
- `dep1_out`, `dep2_out`  out  1 each  dependency flags. `dep2_out` = 0 when there is no rs2.
- `tag1_out`, `tag2_out`  out  ROB_W each  dependency tags. `tag2_out` = 0 when there is no rs2.
- `pred_taken_out`  out  1  issued control instruction was predicted taken.

## Operation
- Queue: circular buffer with `head`, `tail` and `count` (width clog2(IQ_DEPTH)+1). Each entry holds instr, pc and pred_taken.
- Push when `in_valid && in_ready`.
- `in_ready = !rst && rdy && !clear && count<IQ_DEPTH && !wait_redir`. Fullness is checked without crediting a same-cycle pop.
- Immediates:
  - LUI/AUIPC: U-format.
  - JAL: J-format.
  - JALR/LOAD/OP-IMM: I-format.
  - BRANCH: B-format.
  - STORE: S-format.
  - R-type: 0.
  - All sign-extended.
- Push-time prediction:
  - JAL: set `wait_redir`; next cycle `pred_valid=1`, `pred_pc=pc+imm`; entry pred_taken=1.
  - BRANCH predicted taken (see Configuration): same behaviour, with target `pc+imm`.
  - JALR: set `wait_redir`; no pulse at push time.
  - Otherwise: no action; pred_taken=0.
- Issue condition, evaluated on the head entry:
  - `count>0 && !rob_full`, and
  - `!lsb_full` for LOAD/STORE, `!rs_full` for all other types, and
  - not (JALR && `reg_dep1`).
- On issue:
  - Pop the head and register all `*_out` fields.
  - `issue_valid=1` for one cycle; it is 0 in any cycle without an issue.
- JALR issue: same-edge `pred_valid=1`, `pred_pc=(reg_val1+imm)&~1`.
- Every `pred_valid` pulse clears `wait_redir`. The fetcher discards its in-flight fetch on the pulse.
- `clear` (priority below `rst`, above everything else):
  - `count`, `head`, `tail` and `wait_redir` go to 0.
  - `issue_valid` and `pred_valid` go to 0 next cycle.
  - No push or issue happens that cycle.
- Simultaneous push and pop: both occur; `count` is unchanged.
- Pointers wrap modulo IQ_DEPTH.

## Timing
- Reset: all registered outputs, `count`, pointers and `wait_redir` are 0. `in_ready` is 0 while `rst` is high.
- Push at edge N: entry is at the head by cycle N+1 if the queue was empty. Earliest `issue_valid` is high after edge N+1 (2-cycle fetch-to-issue).
- JAL/taken-branch push at edge N: `pred_valid` is high for the cycle after edge N+1. `in_ready` is 0 from after edge N until that pulse.
- `reg_id*` and `rob_id_out` are combinational; register-file lookup completes within the cycle.
- `rdy=0`: no push, no issue, no state change; outputs hold their values (including a high `issue_valid`).
- Reset mid-operation discards all queued entries and any pending redirect.

## Configuration
- `BTFN_PREDICT_EN`:
  - Defined: backward branches (imm[31]=1) are predicted taken and redirect as above. Forward branches are not-taken.
  - Undefined: all branches are not-taken, cause no redirect, and `pred_taken_out=0`.

## Test plan
- Reset, then push ADDI x1,x0,5 at pc 0x0: `issue_valid` is high 2 cycles later; `rd_out=1`, `val2_out=5`, `dep2_out=0`.
- Push 5 instructions back-to-back with `rob_full=1` and IQ_DEPTH=4: `in_ready` drops after the 4th push. Release `rob_full`: 4 issues in consecutive cycles in FIFO order.
- Queue holds a LW and then an ADD, with `lsb_full=1`, `rs_full=0`: no issue (in-order head block). Drop `lsb_full`: LW issues, then ADD.
- JAL at pc 0x100, imm 0x20: `pred_valid` with `pred_pc=0x120` one cycle after push; `in_ready` low until then. Repeat with JALR where `reg_dep1=1`: no issue until the dependency clears, then `pred_pc=rs1+imm`.
- BEQ at pc 0x200, imm −8: with `BTFN_PREDICT_EN`, `pred_pc=0x1F8` and `pred_taken_out=1`; without it, no pulse and `pred_taken_out=0`.
- Queue holding 3 entries plus a pending redirect, then `clear` asserted together with `in_valid`: next cycle count=0, no issue, no push, `in_ready=1`.

Source files
------------

// File: rtl/decode_issue_queue_if.sv
// Signal bundle between decode_issue_queue and its fetcher, register file, RoB/RS/LSB and issue consumers.
// master = environment side, slave = the decode/issue stage.
interface decode_issue_queue_if #(
  parameter int ROB_W = 4
);
  logic             rdy;
  logic             clear;
  logic             in_valid;
  logic [31:0]      in_instr;
  logic [31:0]      in_pc;
  logic             in_ready;
  logic             pred_valid;
  logic [31:0]      pred_pc;
  logic             rob_full;
  logic             rs_full;
  logic             lsb_full;
  logic [4:0]       reg_id1;
  logic [4:0]       reg_id2;
  logic [31:0]      reg_val1;
  logic [31:0]      reg_val2;
  logic             reg_dep1;
  logic             reg_dep2;
  logic [ROB_W-1:0] reg_tag1;
  logic [ROB_W-1:0] reg_tag2;
  logic [ROB_W-1:0] rob_id_in;
  logic [ROB_W-1:0] rob_id_out;
  logic             issue_valid;
  logic [31:0]      instr_out;
  logic [31:0]      pc_out;
  logic [6:0]       type_out;
  logic [2:0]       op_out;
  logic [31:0]      imm_out;
  logic [4:0]       rd_out;
  logic [31:0]      val1_out;
  logic [31:0]      val2_out;
  logic             dep1_out;
  logic             dep2_out;
  logic [ROB_W-1:0] tag1_out;
  logic [ROB_W-1:0] tag2_out;
  logic             pred_taken_out;

  modport master (
    output rdy, clear, in_valid, in_instr, in_pc, rob_full, rs_full, lsb_full,
           reg_val1, reg_val2, reg_dep1, reg_dep2, reg_tag1, reg_tag2, rob_id_in,
    input  in_ready, pred_valid, pred_pc, reg_id1, reg_id2, rob_id_out, issue_valid,
           instr_out, pc_out, type_out, op_out, imm_out, rd_out, val1_out, val2_out,
           dep1_out, dep2_out, tag1_out, tag2_out, pred_taken_out
  );

  modport slave (
    input  rdy, clear, in_valid, in_instr, in_pc, rob_full, rs_full, lsb_full,
           reg_val1, reg_val2, reg_dep1, reg_dep2, reg_tag1, reg_tag2, rob_id_in,
    output in_ready, pred_valid, pred_pc, reg_id1, reg_id2, rob_id_out, issue_valid,
           instr_out, pc_out, type_out, op_out, imm_out, rd_out, val1_out, val2_out,
           dep1_out, dep2_out, tag1_out, tag2_out, pred_taken_out
  );
endinterface

// File: rtl/decode_issue_queue.sv
// Instruction queue + decode/issue stage with JAL/JALR/branch next-PC redirect and RoB flush.
// Define BTFN_PREDICT_EN to predict backward branches taken; otherwise all branches are not-taken.
module decode_issue_queue #(
  parameter int IQ_DEPTH = 4,
  parameter int ROB_W    = 4
) (
  input logic                 clk,
  input logic                 rst,
  decode_issue_queue_if.slave bus
);
  localparam int PTR_W = (IQ_DEPTH > 1) ? $clog2(IQ_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(IQ_DEPTH);
`ifdef BTFN_PREDICT_EN
  localparam bit BTFN = 1'b1;
`else
  localparam bit BTFN = 1'b0;
`endif

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  function automatic logic [31:0] imm_of(input logic [31:0] ins);
    logic [31:0] imm;
    imm = '0;
    case (ins[6:0])
      OPC_LUI, OPC_AUIPC:            imm = {ins[31:12], 12'b0};
      OPC_JAL:                       imm = {{12{ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0};
      OPC_JALR, OPC_LOAD, OPC_OPIMM: imm = {{20{ins[31]}}, ins[31:20]};
      OPC_BRANCH:                    imm = {{20{ins[31]}}, ins[7], ins[30:25], ins[11:8], 1'b0};
      OPC_STORE:                     imm = {{20{ins[31]}}, ins[31:25], ins[11:7]};
      default:                       imm = '0;
    endcase
    return imm;
  endfunction

  logic [31:0]         instr_q [IQ_DEPTH];
  logic [31:0]         pc_q    [IQ_DEPTH];
  logic [IQ_DEPTH-1:0] taken_q;
  logic [PTR_W-1:0]    head, tail;
  logic [CNT_W-1:0]    count;
  logic                wait_redir;
  logic                redir_pend;
  logic [31:0]         redir_tgt;

  // Push-side predecode of the fetched word
  logic [6:0]  in_opc;
  logic [31:0] in_imm;
  logic        in_jal, in_jalr, in_br_taken, in_redir, in_taken;
  logic        push;

  assign in_opc      = bus.in_instr[6:0];
  assign in_imm      = imm_of(bus.in_instr);
  assign in_jal      = (in_opc == OPC_JAL);
  assign in_jalr     = (in_opc == OPC_JALR);
  assign in_br_taken = (in_opc == OPC_BRANCH) && BTFN && in_imm[31];
  assign in_redir    = in_jal || in_br_taken;
  assign in_taken    = in_redir || in_jalr;

  assign bus.in_ready = !rst && bus.rdy && !bus.clear && (count < DEPTH_C) && !wait_redir;
  assign push         = bus.in_valid && bus.in_ready;

  // Head-entry decode; register file is looked up combinationally on rs1/rs2
  logic [31:0] h_instr, h_pc, h_imm;
  logic [6:0]  h_opc;
  logic        h_taken, h_mem, h_jalr, h_two_src, h_no_rd, unit_ok, issue;

  assign h_instr   = instr_q[head];
  assign h_pc      = pc_q[head];
  assign h_taken   = taken_q[head];
  assign h_opc     = h_instr[6:0];
  assign h_imm     = imm_of(h_instr);
  assign h_mem     = (h_opc == OPC_LOAD) || (h_opc == OPC_STORE);
  assign h_jalr    = (h_opc == OPC_JALR);
  assign h_no_rd   = (h_opc == OPC_BRANCH) || (h_opc == OPC_STORE);
  assign h_two_src = h_no_rd || (h_opc == OPC_OP);
  assign unit_ok   = h_mem ? !bus.lsb_full : !bus.rs_full;

  assign bus.reg_id1    = h_instr[19:15];
  assign bus.reg_id2    = h_instr[24:20];
  assign bus.rob_id_out = bus.rob_id_in;

  assign issue = !rst && bus.rdy && !bus.clear && (count != '0) && !bus.rob_full
                 && unit_ok && !(h_jalr && bus.reg_dep1);

  // Queue payload: written only on an accepted push, never reset
  always_ff @(posedge clk) begin
    if (push) begin
      instr_q[tail] <= bus.in_instr;
      pc_q[tail]    <= bus.in_pc;
      taken_q[tail] <= in_taken;
      if (in_redir) redir_tgt <= bus.in_pc + in_imm;
    end
  end

  // Control, redirect and issue registers
  always_ff @(posedge clk) begin
    if (rst) begin
      head               <= '0;
      tail               <= '0;
      count              <= '0;
      wait_redir         <= 1'b0;
      redir_pend         <= 1'b0;
      bus.pred_valid     <= 1'b0;
      bus.pred_pc        <= '0;
      bus.issue_valid    <= 1'b0;
      bus.instr_out      <= '0;
      bus.pc_out         <= '0;
      bus.type_out       <= '0;
      bus.op_out         <= '0;
      bus.imm_out        <= '0;
      bus.rd_out         <= '0;
      bus.val1_out       <= '0;
      bus.val2_out       <= '0;
      bus.dep1_out       <= 1'b0;
      bus.dep2_out       <= 1'b0;
      bus.tag1_out       <= '0;
      bus.tag2_out       <= '0;
      bus.pred_taken_out <= 1'b0;
    end else if (bus.clear) begin
      head            <= '0;
      tail            <= '0;
      count           <= '0;
      wait_redir      <= 1'b0;
      redir_pend      <= 1'b0;
      bus.pred_valid  <= 1'b0;
      bus.issue_valid <= 1'b0;
    end else if (bus.rdy) begin
      if (push) tail <= tail + PTR_W'(1);
      if (issue) head <= head + PTR_W'(1);
      if (push && !issue) count <= count + CNT_W'(1);
      else if (!push && issue) count <= count - CNT_W'(1);

      bus.issue_valid <= issue;
      bus.pred_valid  <= 1'b0;
      // At most one redirect is outstanding: wait_redir blocks pushes until its pulse
      if (redir_pend) begin
        bus.pred_valid <= 1'b1;
        bus.pred_pc    <= redir_tgt;
        redir_pend     <= 1'b0;
        wait_redir     <= 1'b0;
      end else if (issue && h_jalr) begin
        bus.pred_valid <= 1'b1;
        bus.pred_pc    <= (bus.reg_val1 + h_imm) & ~32'd1;
        wait_redir     <= 1'b0;
      end
      if (push && (in_redir || in_jalr)) wait_redir <= 1'b1;
      if (push && in_redir) redir_pend <= 1'b1;

      if (issue) begin
        bus.instr_out      <= h_instr;
        bus.pc_out         <= h_pc;
        bus.type_out       <= h_opc;
        bus.op_out         <= h_instr[14:12];
        bus.imm_out        <= h_imm;
        bus.rd_out         <= h_no_rd ? 5'd0 : h_instr[11:7];
        bus.val1_out       <= bus.reg_val1;
        bus.dep1_out       <= bus.reg_dep1;
        bus.tag1_out       <= bus.reg_tag1;
        bus.val2_out       <= h_two_src ? bus.reg_val2 : h_imm;
        bus.dep2_out       <= h_two_src ? bus.reg_dep2 : 1'b0;
        bus.tag2_out       <= h_two_src ? bus.reg_tag2 : '0;
        bus.pred_taken_out <= h_taken;
      end
    end
  end
endmodule

// File: tb/tb_decode_issue_queue.sv
// Self-checking bench for decode_issue_queue: queue-based reference model plus directed literal checks.
module tb_decode_issue_queue;
  localparam int IQ_DEPTH = 4;
  localparam int ROB_W    = 4;
`ifdef BTFN_PREDICT_EN
  localparam bit BTFN = 1'b1;
`else
  localparam bit BTFN = 1'b0;
`endif
  localparam logic [6:0] M_JAL = 7'h6F, M_JALR = 7'h67, M_BR = 7'h63;
  localparam logic [6:0] M_LD  = 7'h03, M_ST   = 7'h23, M_OP = 7'h33;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  decode_issue_queue_if #(.ROB_W(ROB_W)) bus ();
  decode_issue_queue #(.IQ_DEPTH(IQ_DEPTH), .ROB_W(ROB_W)) dut (.clk(clk), .rst(rst), .bus(bus));

  // Register file seen by the DUT
  logic [31:0]      rf_val [32];
  logic             rf_dep [32];
  logic [ROB_W-1:0] rf_tag [32];
  assign bus.reg_val1 = rf_val[bus.reg_id1];
  assign bus.reg_val2 = rf_val[bus.reg_id2];
  assign bus.reg_dep1 = rf_dep[bus.reg_id1];
  assign bus.reg_dep2 = rf_dep[bus.reg_id2];
  assign bus.reg_tag1 = rf_tag[bus.reg_id1];
  assign bus.reg_tag2 = rf_tag[bus.reg_id2];

  int n_vec = 0;
  int n_err = 0;
  bit started = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Immediate extraction by shifting and masking the instruction word
  function automatic logic [31:0] m_imm(input logic [31:0] i);
    logic signed [31:0] s, hi, s20, s25;
    logic [31:0] hu, u20, u25;
    s = i; hi = s >>> 31; s20 = s >>> 20; s25 = s >>> 25;
    hu = hi; u20 = s20; u25 = s25;
    case (i[6:0])
      7'h37, 7'h17:        return i & 32'hFFFF_F000;
      7'h6F:               return (hu << 20) | (i & 32'h000F_F000) | ((i >> 9) & 32'h800) | ((i >> 20) & 32'h7FE);
      7'h67, 7'h03, 7'h13: return u20;
      7'h63:               return (hu << 12) | ((i << 4) & 32'h800) | ((i >> 20) & 32'h7E0) | ((i >> 7) & 32'h1E);
      7'h23:               return (u25 << 5) | ((i >> 7) & 32'h1F);
      default:             return 32'h0;
    endcase
  endfunction

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        pt;
  } ent_t;

  typedef struct {
    logic [31:0]      instr, pc, imm, v1, v2;
    logic [4:0]       rd;
    logic             d1, d2, pt;
    logic [ROB_W-1:0] t1, t2;
  } out_t;

  ent_t        mq[$];
  logic        m_wait, m_pend;
  logic [31:0] m_tgt;
  logic        e_iv, e_pv;
  logic [31:0] e_ppc;
  out_t        e_out;

  // Reference model: advances on every rising edge from the inputs stable at that edge
  always @(posedge clk) begin
    bit ok_push, iss, pv, two_src, taken;
    ent_t h;
    logic [6:0] opc;
    logic [4:0] rs1, rs2;
    logic [31:0] imm, ppc;
    if (rst) begin
      mq.delete(); m_wait = 0; m_pend = 0; m_tgt = '0;
      e_iv = 0; e_pv = 0; e_ppc = '0;
      e_out = '{default: '0};
    end else if (bus.clear) begin
      mq.delete(); m_wait = 0; m_pend = 0; e_iv = 0; e_pv = 0;
    end else if (bus.rdy) begin
      ok_push = bus.in_valid && (mq.size() < IQ_DEPTH) && !m_wait;
      iss = 0;
      opc = '0; rs1 = '0; rs2 = '0;
      if (mq.size() != 0) begin
        h = mq[0];
        opc = h.instr[6:0]; rs1 = h.instr[19:15]; rs2 = h.instr[24:20];
        iss = !bus.rob_full && ((opc == M_LD || opc == M_ST) ? !bus.lsb_full : !bus.rs_full)
              && !(opc == M_JALR && rf_dep[rs1]);
      end
      pv = 0; ppc = e_ppc;
      if (m_pend) begin pv = 1; ppc = m_tgt; m_pend = 0; m_wait = 0; end
      if (iss) begin
        void'(mq.pop_front());
        two_src = (opc == M_BR) || (opc == M_ST) || (opc == M_OP);
        imm = m_imm(h.instr);
        e_out.instr = h.instr; e_out.pc = h.pc; e_out.imm = imm; e_out.pt = h.pt;
        e_out.rd = (opc == M_BR || opc == M_ST) ? 5'd0 : h.instr[11:7];
        e_out.v1 = rf_val[rs1]; e_out.d1 = rf_dep[rs1]; e_out.t1 = rf_tag[rs1];
        e_out.v2 = two_src ? rf_val[rs2] : imm;
        e_out.d2 = two_src ? rf_dep[rs2] : 1'b0;
        e_out.t2 = two_src ? rf_tag[rs2] : '0;
        if (opc == M_JALR) begin pv = 1; ppc = (rf_val[rs1] + imm) & ~32'd1; m_wait = 0; end
      end
      e_iv = iss;
      if (ok_push) begin
        opc = bus.in_instr[6:0];
        imm = m_imm(bus.in_instr);
        taken = (opc == M_JAL) || (opc == M_JALR) || (opc == M_BR && BTFN && imm[31]);
        mq.push_back('{instr: bus.in_instr, pc: bus.in_pc, pt: taken});
        if (opc == M_JAL || (opc == M_BR && taken)) begin m_wait = 1; m_pend = 1; m_tgt = bus.in_pc + imm; end
        if (opc == M_JALR) m_wait = 1;
      end
      e_pv = pv; e_ppc = ppc;
    end
  end

  // Compare process: every falling edge, all meaningful outputs against the model
  always @(negedge clk) begin
    logic exp_rdy;
    if (started) begin
      exp_rdy = !rst && bus.rdy && !bus.clear && (mq.size() < IQ_DEPTH) && !m_wait;
      check("in_ready", 32'(bus.in_ready), 32'(exp_rdy));
      check("rob_id_out", 32'(bus.rob_id_out), 32'(bus.rob_id_in));
      if (mq.size() != 0) begin
        check("reg_id1", 32'(bus.reg_id1), 32'(mq[0].instr[19:15]));
        check("reg_id2", 32'(bus.reg_id2), 32'(mq[0].instr[24:20]));
      end
      check("issue_valid", 32'(bus.issue_valid), 32'(e_iv));
      check("pred_valid", 32'(bus.pred_valid), 32'(e_pv));
      if (e_pv) check("pred_pc", bus.pred_pc, e_ppc);
      if (e_iv) begin
        check("instr_out", bus.instr_out, e_out.instr);
        check("pc_out", bus.pc_out, e_out.pc);
        check("type_out", 32'(bus.type_out), 32'(e_out.instr[6:0]));
        check("op_out", 32'(bus.op_out), 32'(e_out.instr[14:12]));
        check("imm_out", bus.imm_out, e_out.imm);
        check("rd_out", 32'(bus.rd_out), 32'(e_out.rd));
        check("val1_out", bus.val1_out, e_out.v1);
        check("val2_out", bus.val2_out, e_out.v2);
        check("dep1_out", 32'(bus.dep1_out), 32'(e_out.d1));
        check("dep2_out", 32'(bus.dep2_out), 32'(e_out.d2));
        check("tag1_out", 32'(bus.tag1_out), 32'(e_out.t1));
        check("tag2_out", 32'(bus.tag2_out), 32'(e_out.t2));
        check("pred_taken_out", 32'(bus.pred_taken_out), 32'(e_out.pt));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    bus.rob_id_in = bus.rob_id_in + 1'b1;
  endtask

  task automatic push(input logic [31:0] instr, input logic [31:0] pc);
    bus.in_instr = instr; bus.in_pc = pc; bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
  endtask

  function automatic logic [31:0] addi(input logic [4:0] rd, input logic [11:0] imm);
    return {imm, 5'd0, 3'b000, rd, 7'h13};
  endfunction

  localparam logic [31:0] I_ADD  = 32'h002081B3; // add  x3,x1,x2
  localparam logic [31:0] I_LW   = 32'h00812203; // lw   x4,8(x2)
  localparam logic [31:0] I_JAL  = 32'h020000EF; // jal  x1,+0x20
  localparam logic [31:0] I_JALR = 32'h004280E7; // jalr x1,4(x5)
  localparam logic [31:0] I_BEQ  = 32'hFE208CE3; // beq  x1,x2,-8
  localparam logic [31:0] I_LUI  = 32'h123452B7; // lui  x5,0x12345
  localparam logic [31:0] I_SW   = 32'hFE312E23; // sw   x3,-4(x2)

  initial begin
    logic [31:0] burst [5];
    #100000;
    $display("FAIL watchdog: simulation did not reach its end, got %0d vectors, expected completion", n_vec);
    $fatal(1, "timeout");
    burst[0] = '0;
  end

  initial begin
    logic [31:0] burst [5];
    for (int r = 0; r < 32; r++) begin rf_val[r] = '0; rf_dep[r] = 1'b0; rf_tag[r] = '0; end
    rst = 1'b1;
    bus.rdy = 1'b1; bus.clear = 1'b0; bus.in_valid = 1'b0; bus.in_instr = '0; bus.in_pc = '0;
    bus.rob_full = 1'b0; bus.rs_full = 1'b0; bus.lsb_full = 1'b0; bus.rob_id_in = 4'd5;

    // Reset state
    @(posedge clk); #1;
    started = 1'b1;
    check("rst_in_ready", 32'(bus.in_ready), 0);
    check("rst_issue_valid", 32'(bus.issue_valid), 0);
    check("rst_pred_valid", 32'(bus.pred_valid), 0);
    step();
    rst = 1'b0;

    // ADDI x1,x0,5 at pc 0: issued two edges after the push
    push(addi(5'd1, 12'd5), 32'h0);
    check("addi_not_yet", 32'(bus.issue_valid), 0);
    step();
    check("addi_issue", 32'(bus.issue_valid), 1);
    check("addi_rd", 32'(bus.rd_out), 1);
    check("addi_val2", bus.val2_out, 5);
    check("addi_dep2", 32'(bus.dep2_out), 0);
    step();
    check("addi_one_pulse", 32'(bus.issue_valid), 0);

    // Five pushes into a 4-deep queue while the RoB is full, then drain in order
    burst[0] = addi(5'd1, 12'd1); burst[1] = I_LUI; burst[2] = I_SW;
    burst[3] = addi(5'd2, 12'hFFF); burst[4] = addi(5'd7, 12'd7);
    rf_val[2] = 32'h100; rf_val[3] = 32'h33;
    bus.rob_full = 1'b1;
    for (int k = 0; k < 5; k++) begin
      push(burst[k], 32'h10 + 32'(4 * k));
      if (k == 3) check("full_in_ready", 32'(bus.in_ready), 0);
    end
    check("full_no_issue", 32'(bus.issue_valid), 0);
    bus.rob_full = 1'b0;
    step();
    for (int k = 0; k < 4; k++) begin
      check("drain_valid", 32'(bus.issue_valid), 1);
      check("drain_pc", bus.pc_out, 32'h10 + 32'(4 * k));
      if (k == 1) check("lui_imm", bus.imm_out, 32'h1234_5000);
      if (k == 2) begin
        check("sw_imm", bus.imm_out, 32'hFFFF_FFFC);
        check("sw_rd", 32'(bus.rd_out), 0);
        check("sw_val2", bus.val2_out, 32'h33);
      end
      step();
    end
    check("drain_done", 32'(bus.issue_valid), 0);

    // LW blocked by the LSB holds back the ADD behind it
    rf_val[1] = 32'hDEAD; rf_dep[1] = 1'b1; rf_tag[1] = 4'd3;
    bus.lsb_full = 1'b1;
    push(I_LW, 32'h40);
    push(I_ADD, 32'h44);
    step(); step();
    check("lsb_block", 32'(bus.issue_valid), 0);
    bus.lsb_full = 1'b0;
    step();
    check("lw_issue", 32'(bus.issue_valid), 1);
    check("lw_type", 32'(bus.type_out), 32'h03);
    check("lw_val1", bus.val1_out, 32'h100);
    check("lw_val2_imm", bus.val2_out, 8);
    step();
    check("add_issue", 32'(bus.issue_valid), 1);
    check("add_type", 32'(bus.type_out), 32'h33);
    check("add_dep1", 32'(bus.dep1_out), 1);
    check("add_tag1", 32'(bus.tag1_out), 3);
    check("add_rd", 32'(bus.rd_out), 3);
    step();
    rf_dep[1] = 1'b0;

    // JAL redirect pulse one cycle after the push
    push(I_JAL, 32'h100);
    check("jal_in_ready_low", 32'(bus.in_ready), 0);
    check("jal_no_pulse_yet", 32'(bus.pred_valid), 0);
    step();
    check("jal_pred_valid", 32'(bus.pred_valid), 1);
    check("jal_pred_pc", bus.pred_pc, 32'h120);
    check("jal_in_ready_back", 32'(bus.in_ready), 1);
    check("jal_pred_taken", 32'(bus.pred_taken_out), 1);
    step();
    check("jal_one_pulse", 32'(bus.pred_valid), 0);

    // JALR waits for its base register
    rf_val[5] = 32'h1001; rf_dep[5] = 1'b1;
    push(I_JALR, 32'h104);
    step(); step(); step();
    check("jalr_blocked", 32'(bus.issue_valid), 0);
    check("jalr_in_ready", 32'(bus.in_ready), 0);
    rf_dep[5] = 1'b0;
    step();
    check("jalr_issue", 32'(bus.issue_valid), 1);
    check("jalr_pred_valid", 32'(bus.pred_valid), 1);
    check("jalr_pred_pc", bus.pred_pc, 32'h1004);
    step();

    // Backward BEQ
    push(I_BEQ, 32'h200);
    step();
    check("beq_issue", 32'(bus.issue_valid), 1);
    check("beq_imm", bus.imm_out, 32'hFFFF_FFF8);
    check("beq_rd", 32'(bus.rd_out), 0);
`ifdef BTFN_PREDICT_EN
    check("beq_pred_valid", 32'(bus.pred_valid), 1);
    check("beq_pred_pc", bus.pred_pc, 32'h1F8);
    check("beq_pred_taken", 32'(bus.pred_taken_out), 1);
`else
    check("beq_pred_valid", 32'(bus.pred_valid), 0);
    check("beq_pred_taken", 32'(bus.pred_taken_out), 0);
`endif
    step();

    // rdy low freezes a high issue_valid
    push(addi(5'd6, 12'd9), 32'h300);
    step();
    check("rdy_issue", 32'(bus.issue_valid), 1);
    bus.rdy = 1'b0;
    step(); step();
    check("rdy_hold_issue", 32'(bus.issue_valid), 1);
    check("rdy_in_ready", 32'(bus.in_ready), 0);
    bus.rdy = 1'b1;
    step();
    check("rdy_release", 32'(bus.issue_valid), 0);

    // Flush with three queued entries and a pending JAL redirect, push attempted alongside
    bus.rob_full = 1'b1;
    push(addi(5'd1, 12'd1), 32'h400);
    push(addi(5'd2, 12'd2), 32'h404);
    push(I_JAL, 32'h408);
    bus.clear = 1'b1;
    push(addi(5'd3, 12'd3), 32'h40C);
    bus.clear = 1'b0; bus.rob_full = 1'b0;
    #1;
    check("clr_in_ready", 32'(bus.in_ready), 1);
    check("clr_issue", 32'(bus.issue_valid), 0);
    check("clr_pred", 32'(bus.pred_valid), 0);
    step(); step();
    check("clr_empty", 32'(bus.issue_valid), 0);
    check("clr_no_pred", 32'(bus.pred_valid), 0);

    // Reset mid-operation drops queued JAL and its redirect
    bus.rob_full = 1'b1;
    push(I_JAL, 32'h500);
    rst = 1'b1;
    step();
    check("mid_rst_in_ready", 32'(bus.in_ready), 0);
    rst = 1'b0; bus.rob_full = 1'b0;
    step(); step();
    check("mid_rst_issue", 32'(bus.issue_valid), 0);
    check("mid_rst_pred", 32'(bus.pred_valid), 0);
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
